bm_dl_16_4_seq_encoder: RTL and testbench

BM_DL_16_4_SEQ_ENCODER -- requirements
Module: bm_dl_16_4_seq_encoder

---
 rtl/bm_dl_16_4_seq_encoder_pkg.sv | 21 ++
 rtl/bm_dl_16_4_seq_encoder_if.sv | 14 +
 rtl/bm_dl_16_4_seq_encoder_lsb_find16.sv | 15 +
 rtl/bm_dl_16_4_seq_encoder.sv | 71 +++++++
 tb/tb_bm_dl_16_4_seq_encoder.sv | 129 ++++++++++++
 5 files changed

// File: rtl/bm_dl_16_4_seq_encoder_pkg.sv
// bm_dl_16_4_seq_encoder_pkg: shared widths, state encoding and mask helpers
package bm_dl_16_4_seq_encoder_pkg;
    localparam int VEC_W  = 16;
    localparam int CODE_W = 4;
    typedef logic [VEC_W-1:0]  vec_t;
    typedef logic [CODE_W-1:0] code_t;
    localparam code_t ZERO_CODE = '0;
    typedef enum logic {IDLE, EMIT} state_t;
    // Y is declared [0:15]; map Y[i] onto mask bit i so code i tracks request i
    function automatic vec_t to_mask(input logic [0:VEC_W-1] y);
        vec_t r;
        for (int i = 0; i < VEC_W; i++) r[i] = y[i];
        return r;
    endfunction
    function automatic vec_t onehot(input code_t c);
        vec_t r;
        r = '0;
        r[c] = 1'b1;
        return r;
    endfunction
endpackage

// File: rtl/bm_dl_16_4_seq_encoder_if.sv
// bm_dl_16_4_seq_encoder_if: request-vector in / code-beat out handshake bundle
interface bm_dl_16_4_seq_encoder_if;
    import bm_dl_16_4_seq_encoder_pkg::*;
    logic [0:VEC_W-1] Y;
    logic             in_valid;
    logic             in_ready;
    code_t            W;
    logic             En;
    logic             out_valid;
    logic             out_ready;
    logic             last;
    modport master (output Y, in_valid, out_ready, input in_ready, W, En, out_valid, last);
    modport slave  (input Y, in_valid, out_ready, output in_ready, W, En, out_valid, last);
endinterface

// File: rtl/bm_dl_16_4_seq_encoder_lsb_find16.sv
// lsb_find16: combinational lowest-set-bit index of a 16-bit vector plus any-set flag
module lsb_find16
    import bm_dl_16_4_seq_encoder_pkg::*;
(
    input  vec_t  vec,
    output code_t idx,
    output logic  any
);
    // scan from the top so the lowest set bit is the final winner
    always_comb begin
        idx = ZERO_CODE;
        for (int i = VEC_W - 1; i >= 0; i--) if (vec[i]) idx = code_t'(i);
        any = |vec;
    end
endmodule

// File: rtl/bm_dl_16_4_seq_encoder.sv
// bm_dl_16_4_seq_encoder: serialises a 16-bit request vector into 4-bit code beats; BM_DL_SEQ_ENCODER_DRAIN_EN emits every set bit, otherwise only the lowest
module bm_dl_16_4_seq_encoder
    import bm_dl_16_4_seq_encoder_pkg::*;
(
    input logic                          clock,
    input logic                          resetn,
    bm_dl_16_4_seq_encoder_if.slave      bus
);
    state_t state, state_nxt;
    vec_t   mask, mask_nxt;
    code_t  w_q, w_nxt, idx;
    logic   en_q, en_nxt, last_q, last_nxt, any, emit_nxt;

    // outputs are computed from the next mask so they can be registered alongside it
    lsb_find16 u_find (.vec(mask_nxt), .idx(idx), .any(any));

    // state, mask and output registers
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state  <= IDLE;
            mask   <= '0;
            w_q    <= ZERO_CODE;
            en_q   <= 1'b0;
            last_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            mask   <= mask_nxt;
            w_q    <= w_nxt;
            en_q   <= en_nxt;
            last_q <= last_nxt;
        end
    end

    // next state and remaining mask: capture in IDLE, retire the emitted bit on handshake
    always_comb begin
        state_nxt = state;
        mask_nxt  = mask;
        if (state == IDLE) begin
            if (bus.in_valid) begin
                state_nxt = EMIT;
                mask_nxt  = to_mask(bus.Y);
            end
        end else if (bus.out_ready) begin
`ifdef BM_DL_SEQ_ENCODER_DRAIN_EN
            mask_nxt  = mask & ~onehot(w_q);
            state_nxt = last_q ? IDLE : EMIT;
`else
            mask_nxt  = '0;
            state_nxt = IDLE;
`endif
        end
    end

    // next beat contents; idle outputs sit at their reset values
    always_comb begin
        emit_nxt = state_nxt == EMIT;
        w_nxt    = emit_nxt ? idx : ZERO_CODE;
        en_nxt   = emit_nxt & any;
`ifdef BM_DL_SEQ_ENCODER_DRAIN_EN
        last_nxt = emit_nxt & ((mask_nxt & ~onehot(idx)) == '0);
`else
        last_nxt = emit_nxt;
`endif
    end

    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == EMIT;
    assign bus.W         = w_q;
    assign bus.En        = en_q;
    assign bus.last      = last_q;
endmodule

// File: tb/tb_bm_dl_16_4_seq_encoder.sv
// tb_bm_dl_16_4_seq_encoder: directed checks of capture, beat sequencing, stalls and reset
module tb_bm_dl_16_4_seq_encoder;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    int checks = 0;
    int errors = 0;

    bm_dl_16_4_seq_encoder_if bus ();
    bm_dl_16_4_seq_encoder dut (.clock(clock), .resetn(resetn), .bus(bus));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_in_ready"}, int'(bus.in_ready), 1);
        chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
        chk({tag, "_W"}, int'(bus.W), 0);
        chk({tag, "_En"}, int'(bus.En), 0);
        chk({tag, "_last"}, int'(bus.last), 0);
    endtask

    task automatic send(input string tag, input logic [0:15] y);
        chk({tag, "_accept_ready"}, int'(bus.in_ready), 1);
        bus.Y = y;
        bus.in_valid = 1'b1;
        @(negedge clock);
        bus.in_valid = 1'b0;
    endtask

    task automatic beat_chk(input string tag, input int w, input int en, input int last);
        chk({tag, "_valid"}, int'(bus.out_valid), 1);
        chk({tag, "_in_ready"}, int'(bus.in_ready), 0);
        chk({tag, "_W"}, int'(bus.W), w);
        chk({tag, "_En"}, int'(bus.En), en);
        chk({tag, "_last"}, int'(bus.last), last);
    endtask

    task automatic beat(input string tag, input int w, input int en, input int last, input bit stall);
        if (stall) begin
            bus.out_ready = 1'b0;
            beat_chk({tag, "_pre"}, w, en, last);
            @(negedge clock);
        end
        bus.out_ready = 1'b1;
        beat_chk(tag, w, en, last);
        @(negedge clock);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.Y = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clock);
        idle_chk("reset");
        resetn = 1'b1;
        @(negedge clock);
        idle_chk("idle_hold");

        send("b4_9", 16'b0000_1000_0100_0000);
`ifdef BM_DL_SEQ_ENCODER_DRAIN_EN
        beat("b4_9_0", 4, 1, 0, 0);
        beat("b4_9_1", 9, 1, 1, 0);
`else
        beat("b4_9_0", 4, 1, 1, 0);
`endif
        idle_chk("b4_9_done");

        send("b2_13", 16'b0010_0000_0000_0100);
`ifdef BM_DL_SEQ_ENCODER_DRAIN_EN
        beat("b2_13_0", 2, 1, 0, 0);
        beat("b2_13_1", 13, 1, 1, 0);
`else
        beat("b2_13_0", 2, 1, 1, 0);
`endif
        idle_chk("b2_13_done");

        send("zero", 16'h0000);
        beat("zero_0", 0, 0, 1, 1);
        idle_chk("zero_done");

        send("ones", 16'hFFFF);
`ifdef BM_DL_SEQ_ENCODER_DRAIN_EN
        for (int i = 0; i < 16; i++) beat($sformatf("ones_%0d", i), i, 1, int'(i == 15), 1);
`else
        beat("ones_0", 0, 1, 1, 1);
`endif
        idle_chk("ones_done");

        send("ign", 16'b0100_0000_0001_0000);
        bus.Y = 16'hFFFF;
        bus.in_valid = 1'b1;
`ifdef BM_DL_SEQ_ENCODER_DRAIN_EN
        beat("ign_0", 1, 1, 0, 1);
        beat("ign_1", 11, 1, 1, 0);
`else
        beat("ign_0", 1, 1, 1, 1);
`endif
        bus.in_valid = 1'b0;
        idle_chk("ign_done");
        @(negedge clock);
        idle_chk("ign_no_capture");

        send("rst", 16'hFFFF);
`ifdef BM_DL_SEQ_ENCODER_DRAIN_EN
        for (int i = 0; i < 3; i++) beat($sformatf("rst_%0d", i), i, 1, 0, 0);
        beat_chk("rst_pending", 3, 1, 0);
`else
        beat_chk("rst_pending", 0, 1, 1);
`endif
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        idle_chk("rst_after");
        send("b7", 16'b0000_0001_0000_0000);
        beat("b7_0", 7, 1, 1, 0);
        idle_chk("b7_done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
